// File: rtl/cache_control_unit_if.sv
// cache_control_unit_if: CPU load/store port and block-wide memory port of the data cache
interface cache_control_unit_if #(
  parameter int PA_WIDTH  = 32,
  parameter int WRD_WIDTH = 32,
  parameter int BYTE      = 8,
  parameter int BLK_WIDTH = 512
);
  logic                 rd_en;
  logic                 wr_en;
  logic [PA_WIDTH-1:0]  addr;
  logic [WRD_WIDTH-1:0] data_wr;
  logic [BLK_WIDTH-1:0] mem_rd_blk;
  logic [PA_WIDTH-1:0]  mem_addr;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [BLK_WIDTH-1:0] mem_wr_blk;
  logic                 done;
  logic                 hit;
  logic [WRD_WIDTH-1:0] word_out;
  logic [BYTE-1:0]      byte_out;
  modport master (
    output rd_en, wr_en, addr, data_wr, mem_rd_blk,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk, done, hit, word_out, byte_out
  );
  modport slave (
    input  rd_en, wr_en, addr, data_wr, mem_rd_blk,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk, done, hit, word_out, byte_out
  );
endinterface

// File: rtl/cache_control_unit.sv
// cache_control_unit: 4-way set-associative write-back, write-allocate data cache
// with internal tag/data/valid/dirty/LRU arrays and a block-wide memory port.
module cache_control_unit #(
  parameter int PA_WIDTH  = 32,
  parameter int WRD_WIDTH = 32,
  parameter int BYTE      = 8,
  parameter int BLK_WIDTH = 512,
  parameter int NWAYS     = 4,
  parameter int NSETS     = 128,
  parameter int TAG_WIDTH = 19
) (
  input logic clk,
  input logic rst_n,
  cache_control_unit_if.slave cc
);
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
  state_t               r_state;
  logic [PA_WIDTH-1:0]  r_addr;
  logic [WRD_WIDTH-1:0] r_data;
  logic                 r_wr;
  logic                 r_miss;
  logic [1:0]           r_victim;
  logic                 r_done;
  logic                 r_hit;
  logic [WRD_WIDTH-1:0] r_word;
  logic [BYTE-1:0]      r_byte;
  logic [NSETS-1:0]     r_valid [NWAYS];
  logic [NSETS-1:0]     r_dirty [NWAYS];
  logic [1:0]           r_lru   [NWAYS][NSETS];
  logic [TAG_WIDTH-1:0] r_tag   [NWAYS][NSETS];
  logic [BLK_WIDTH-1:0] r_blk   [NWAYS][NSETS];
  logic [TAG_WIDTH-1:0] w_tag;
  logic [6:0]           w_set;
  logic [8:0]           w_wbit;
  logic                 w_hit;
  logic [1:0]           w_hit_way;
  logic [1:0]           w_victim;
  logic [WRD_WIDTH-1:0] w_word;
  assign w_tag  = r_addr[31:13];
  assign w_set  = r_addr[12:6];
  assign w_wbit = {r_addr[5:2], 5'b0};
  // Victim: a way aged 3 unless some way is invalid, in which case the lowest invalid one.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 2'd0;
    w_victim  = 2'd0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (r_valid[i][w_set] && r_tag[i][w_set] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = 2'(i);
      end
      if (r_lru[i][w_set] == 2'd3) w_victim = 2'(i);
    end
    for (int i = NWAYS - 1; i >= 0; i--)
      if (!r_valid[i][w_set]) w_victim = 2'(i);
    w_word = r_wr ? r_data : r_blk[w_hit_way][w_set][w_wbit +: WRD_WIDTH];
  end
  assign cc.mem_wr_en  = r_state == WRITEBACK;
  assign cc.mem_rd_en  = r_state == ALLOCATE;
  assign cc.mem_wr_blk = r_state == WRITEBACK ? r_blk[r_victim][w_set] : '0;
  assign cc.mem_addr   = r_state == WRITEBACK ? {r_tag[r_victim][w_set], w_set, 6'b0} :
                         r_state == ALLOCATE  ? {w_tag, w_set, 6'b0} : '0;
  assign cc.done       = r_done;
  assign cc.hit        = r_hit;
  assign cc.word_out   = r_word;
  assign cc.byte_out   = r_byte;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_wr     <= 1'b0;
      r_miss   <= 1'b0;
      r_victim <= 2'd0;
      r_done   <= 1'b0;
      r_hit    <= 1'b0;
      r_word   <= '0;
      r_byte   <= '0;
      for (int i = 0; i < NWAYS; i++) begin
        r_valid[i] <= '0;
        r_dirty[i] <= '0;
        for (int s = 0; s < NSETS; s++) r_lru[i][s] <= 2'(i);
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (cc.rd_en || cc.wr_en) begin
          r_addr  <= cc.addr;
          r_data  <= cc.data_wr;
          r_wr    <= cc.wr_en;
          r_miss  <= 1'b0;
          r_state <= COMPARE;
        end
        COMPARE: if (w_hit) begin
          if (r_wr) r_dirty[w_hit_way][w_set] <= 1'b1;
          r_word  <= w_word;
          r_byte  <= w_word[{r_addr[1:0], 3'b0} +: BYTE];
          r_done  <= 1'b1;
          r_hit   <= !r_miss;
          r_state <= IDLE;
          for (int i = 0; i < NWAYS; i++)
            if (i == int'(w_hit_way)) r_lru[i][w_set] <= 2'd0;
            else if (r_lru[i][w_set] < r_lru[w_hit_way][w_set]) r_lru[i][w_set] <= r_lru[i][w_set] + 2'd1;
        end else begin
          r_victim <= w_victim;
          r_state  <= r_valid[w_victim][w_set] && r_dirty[w_victim][w_set] ? WRITEBACK : ALLOCATE;
        end
        WRITEBACK: r_state <= ALLOCATE;
        ALLOCATE: begin
          r_valid[r_victim][w_set] <= 1'b1;
          r_dirty[r_victim][w_set] <= 1'b0;
          r_miss                   <= 1'b1;
          r_state                  <= COMPARE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Tag and data contents are meaningless while the valid bit is clear, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == COMPARE && w_hit && r_wr) r_blk[w_hit_way][w_set][w_wbit +: WRD_WIDTH] <= r_data;
    if (r_state == ALLOCATE) begin
      r_blk[r_victim][w_set] <= cc.mem_rd_blk;
      r_tag[r_victim][w_set] <= w_tag;
    end
  end
endmodule

// File: tb/tb_cache_control_unit.sv
// tb_cache_control_unit: directed and random accesses checked against a recency-list cache model
module tb_cache_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  cache_control_unit_if cc ();
  cache_control_unit dut (.clk(clk), .rst_n(rst_n), .cc(cc));
  always #5 clk = ~clk;
  typedef struct {
    logic [18:0]  tag;
    logic [511:0] blk;
    bit           dirty;
  } line_t;
  line_t ms [128][$];
  logic [511:0] mem [int unsigned];
  function automatic logic [511:0] mem_read(input logic [31:0] a);
    logic [511:0] r;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = (a * 32'h9E3779B1) ^ (32'(k) * 32'h01010101) ^ 32'h5A5A0000;
    return r;
  endfunction
  always @(cc.mem_rd_en, cc.mem_addr) cc.mem_rd_blk = cc.mem_rd_en ? mem_read(cc.mem_addr) : '0;
  always @(posedge clk) if (cc.mem_wr_en) mem[cc.mem_addr] = cc.mem_wr_blk;
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " done"}, 512'(cc.done), 0);
    chk({tag, " hit"}, 512'(cc.hit), 0);
    chk({tag, " word_out"}, 512'(cc.word_out), 0);
    chk({tag, " byte_out"}, 512'(cc.byte_out), 0);
    chk({tag, " mem_rd_en"}, 512'(cc.mem_rd_en), 0);
    chk({tag, " mem_wr_en"}, 512'(cc.mem_wr_en), 0);
    chk({tag, " mem_addr"}, 512'(cc.mem_addr), 0);
    chk({tag, " mem_wr_blk"}, cc.mem_wr_blk, 0);
  endtask
  task automatic model_reset();
    for (int s = 0; s < 128; s++) ms[s].delete();
  endtask
  // One access: the model predicts, then the DUT runs and every observable is compared.
  task automatic access(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d, input bit junk);
    int s, wi, idx, n, rdc, wrc, elat;
    logic [18:0] t;
    line_t ln;
    bit eh, ewb;
    logic [31:0] ew, ewa, erda, rda, wra;
    logic [7:0] eb;
    logic [511:0] ewbk, wrb;
    s = int'(a[12:6]); t = a[31:13]; wi = int'(a[5:2]); idx = -1;
    ewb = 0; ewa = 0; ewbk = 0; rda = 0; wra = 0; wrb = 0;
    for (int i = 0; i < ms[s].size(); i++) if (ms[s][i].tag == t) idx = i;
    if (idx >= 0) begin
      ln = ms[s][idx];
      ms[s].delete(idx);
      eh = 1;
    end else begin
      eh = 0;
      if (ms[s].size() == 4) begin
        ln = ms[s].pop_back();
        ewb = ln.dirty;
        ewa = {ln.tag, a[12:6], 6'b0};
        ewbk = ln.blk;
      end
      ln.tag = t;
      ln.blk = mem_read({t, a[12:6], 6'b0});
      ln.dirty = 0;
    end
    if (w) begin
      ln.blk[wi*32 +: 32] = d;
      ln.dirty = 1;
      ew = d;
    end else ew = ln.blk[wi*32 +: 32];
    ms[s].push_front(ln);
    eb = ew[a[1:0]*8 +: 8];
    erda = {t, a[12:6], 6'b0};
    elat = eh ? 2 : (ewb ? 5 : 4);
    @(negedge clk);
    cc.addr = a; cc.data_wr = d; cc.wr_en = w; cc.rd_en = r;
    @(negedge clk);
    cc.rd_en = 0; cc.wr_en = 0;
    n = 1; rdc = 0; wrc = 0;
    while (1) begin
      if (cc.mem_rd_en) begin rdc++; rda = cc.mem_addr; end
      if (cc.mem_wr_en) begin wrc++; wra = cc.mem_addr; wrb = cc.mem_wr_blk; end
      if (cc.done || n >= 12) break;
      if (junk) begin
        cc.addr = $urandom; cc.data_wr = $urandom;
        cc.rd_en = 1'($urandom); cc.wr_en = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    cc.rd_en = 0; cc.wr_en = 0;
    chk("latency", 512'(n), 512'(elat));
    chk("hit", 512'(cc.hit), 512'(eh));
    chk("word_out", 512'(cc.word_out), 512'(ew));
    chk("byte_out", 512'(cc.byte_out), 512'(eb));
    chk("mem_rd count", 512'(rdc), 512'(eh ? 0 : 1));
    chk("mem_wr count", 512'(wrc), 512'(ewb ? 1 : 0));
    if (!eh) chk("fill addr", 512'(rda), 512'(erda));
    if (ewb) begin
      chk("writeback addr", 512'(wra), 512'(ewa));
      chk("writeback blk", wrb, ewbk);
    end
    @(negedge clk);
    chk("done pulse", 512'(cc.done), 0);
  endtask
  initial begin
    logic [511:0] b;
    int n;
    bit seen;
    cc.rd_en = 0; cc.wr_en = 0; cc.addr = 0; cc.data_wr = 0;
    b = mem_read(32'h40);
    b[63:32] = 32'hCAFEBABE;
    mem[32'h40] = b;
    model_reset();
    #12;
    chk_zero("in reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_zero("after reset");
    access(32'h44, 0, 1, 0, 0);
    chk("cold load word", 512'(cc.word_out), 512'(32'hCAFEBABE));
    chk("cold load hit", 512'(cc.hit), 0);
    access(32'h47, 0, 1, 0, 0);
    chk("repeat load byte", 512'(cc.byte_out), 512'(8'hCA));
    access(32'h44, 1, 0, 32'h12345678, 0);
    chk("store hit", 512'(cc.hit), 1);
    access(32'h44, 0, 1, 0, 0);
    chk("load after store", 512'(cc.word_out), 512'(32'h12345678));
    access(32'h2040, 0, 1, 0, 0);
    access(32'h4040, 0, 1, 0, 0);
    access(32'h6040, 0, 1, 0, 0);
    access(32'h8040, 0, 1, 0, 0);
    chk("evict wb word1", mem[32'h40][63:32], 512'(32'h12345678));
    access(32'h40, 0, 1, 0, 0);
    chk("reload after evict hit", 512'(cc.hit), 0);
    @(negedge clk);
    cc.addr = 32'hA040; cc.rd_en = 1;
    @(negedge clk);
    cc.rd_en = 0;
    seen = 0;
    for (n = 0; n < 8 && !seen; n++) begin
      if (cc.mem_rd_en) seen = 1;
      else @(negedge clk);
    end
    chk("reached allocate", 512'(seen), 1);
    rst_n = 0;
    #1;
    chk_zero("reset in allocate");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    access(32'h44, 0, 1, 0, 0);
    chk("miss after reset", 512'(cc.hit), 0);
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      a = {16'b0, 3'($urandom_range(0, 5)), 7'($urandom_range(0, 2)), 6'($urandom)};
      access(a, op != 0, op != 1, $urandom, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_control_unit.md
Name: cache_control_unit

Overview:
- Controller and storage for a 4-way set-associative, write-back, write-allocate data cache: 32 KiB, 128 sets, 64 B blocks, 32-bit words.
- Sits between the CPU load/store port and a block-wide memory port.
- Holds the valid, dirty, LRU, tag and data arrays internally.
- Performs lookup, hit/miss resolution, dirty-victim write-back, block fill and word/byte return.

Parameters:
- PA_WIDTH, 32, physical address width.
- WRD_WIDTH, 32, CPU word width.
- BYTE, 8, byte width.
- BLK_WIDTH, 512, block width (16 words).
- NWAYS, 4, associativity.
- NSETS, 128, number of sets.
- TAG_WIDTH, 19, tag width (PA_WIDTH-7-6).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_en  in  1  load request.
- wr_en  in  1  store request.
- addr  in  PA_WIDTH  byte address. Fields: tag [31:13], set [12:6], word [5:2], byte [1:0].
- data_wr  in  WRD_WIDTH  store data.
- mem_rd_blk  in  BLK_WIDTH  block returned by memory.
- mem_addr  out  PA_WIDTH  block-aligned memory address (low 6 bits = 0).
- mem_rd_en  out  1  memory block read.
- mem_wr_en  out  1  memory block write.
- mem_wr_blk  out  BLK_WIDTH  victim block to memory.
- done  out  1  one-cycle pulse when an access completes.
- hit  out  1  access hit on first lookup; valid while done=1.
- word_out  out  WRD_WIDTH  accessed word.
- byte_out  out  BYTE  byte addr[1:0] of word_out, little-endian (byte 0 = bits 7:0).

Behaviour:
- Reset (async):
  - state=IDLE; all valid=0, dirty=0; lru[w][s]=w.
  - done, hit, word_out, byte_out, all mem_* = 0.
  - Any in-flight access is dropped, including one interrupted by reset.
- IDLE:
  - If rd_en or wr_en, latch addr, data_wr and op, then go to COMPARE.
  - If both are high, the request is a store.
  - rd_en/wr_en are ignored in every state except IDLE.
- COMPARE: hit = any way with valid=1 and matching tag in the set.
  - On hit, at the clock edge:
    - Load: word_out = selected word.
    - Store: replace selected word with data_wr, set dirty=1, word_out = data_wr.
    - byte_out is derived from word_out.
    - LRU update: hit way age becomes 0; ways with age below the hit way's old age increment.
    - Pulse done=1 next cycle; hit = 1 if no fill occurred for this access, else 0. Return to IDLE.
  - On miss, pick the victim: lowest-index invalid way, else the way with age 3.
    - Victim valid and dirty: go to WRITEBACK.
    - Otherwise: go to ALLOCATE.
- WRITEBACK (1 cycle): mem_wr_en=1, mem_addr={victim tag, set, 6'b0}, mem_wr_blk=victim data. Memory captures at the clock edge. Then go to ALLOCATE.
- ALLOCATE (1 cycle): mem_rd_en=1, mem_addr={tag, set, 6'b0}.
  - mem_rd_blk is valid combinationally in this cycle.
  - At the edge: victim data=mem_rd_blk, tag written, valid=1, dirty=0, miss flag set. Return to COMPARE, which then hits.
- mem_* are combinational from state; mem_wr_blk=0 outside WRITEBACK. done, hit, word_out, byte_out are registered.
- word_out and byte_out hold until the next completion. done is 0 except for its one-cycle pulse.
- Latency from the accept edge to the done cycle:
  - Hit: 2 cycles.
  - Clean miss: 4 cycles.
  - Dirty miss: 5 cycles.
- Word k of a block occupies bits [32k+31:32k].

Test Plan:
- Cold load 0x0000_0044 with memory word1 = 0xCAFEBABE:
  - Sequence COMPARE->ALLOCATE (mem_rd_en, mem_addr=0x40)->COMPARE.
  - done with hit=0, word_out=0xCAFEBABE, byte_out=0xBE.
- Repeat load 0x0000_0047 -> done 2 cycles after accept, hit=1, word_out=0xCAFEBABE, byte_out=0xCA, no mem_* activity.
- Store 0x12345678 to 0x0000_0044 (hit) -> hit=1, word_out=0x12345678. A following load of 0x44 returns 0x12345678.
- Fill set 1 with 0x2040, 0x4040, 0x6040, then access 0x8040:
  - Victim is LRU block 0x0040 (dirty).
  - WRITEBACK shows mem_wr_en=1, mem_addr=0x40, word1 of mem_wr_blk=0x12345678, then ALLOCATE at 0x8040.
- Load 0x0000_0040 after that eviction -> miss (hit=0). Victim is the LRU clean way, so no WRITEBACK cycle.
- Assert rst_n=0 during ALLOCATE -> all outputs 0 immediately. A subsequent load of a previously cached address misses.
